fetch_decode: RTL and testbench

- Instruction-fetch stage of the 16-bit pipelined core.
- Owns the PC and runs a req/ack handshake with instruction memory.
- Splits each returned 16-bit word into format/opcode/register/immediate/jump fields.
- Presents the fields, registered, to the IF/ID pipeline register, with valid and stall control and a redirect input from later stages.

---
 rtl/fetch_decode_pkg.sv | 47 ++++
 rtl/fetch_decode_if.sv | 25 ++
 rtl/fetch_decode_instr_field_decode.sv | 51 +++++
 rtl/fetch_decode.sv | 164 ++++++++++++++++
 tb/tb_fetch_decode.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared types for the fetch/decode stage: instruction formats, FSM states,
// field bit positions and the decoded-instruction record.
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam int FMT_HI = 15;
  localparam int FMT_LO = 14;
  localparam int OPC_HI = 13;
  localparam int OPC_LO = 10;
  localparam int RD_HI  = 9;
  localparam int RD_LO  = 7;
  localparam int R1_HI  = 6;
  localparam int R1_LO  = 4;
  localparam int R2_HI  = 3;
  localparam int R2_LO  = 1;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 1;
  localparam int JMP_HI = 9;
  localparam int JMP_LO = 0;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10
  } fetch_state_e;

  typedef struct packed {
    fmt_e             fmt;
    logic [3:0]       opcode;
    logic [2:0]       reg_d;
    logic [2:0]       reg1;
    logic [2:0]       reg2;
    logic [2:0]       imm;
    logic             imm_flag;
    logic [PC_W-1:0]  jmp_loc;
  } decoded_instr_t;

endpackage

// File: rtl/fetch_decode_if.sv
// Instruction-memory request/acknowledge bus between fetch stage and imem.
interface fetch_decode_if #(
  parameter int ADDR_W = 16
) ();

  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack_i;
  logic [15:0]       imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );

endinterface

// File: rtl/fetch_decode_instr_field_decode.sv
// Combinational split of a 16-bit instruction word into its format-dependent
// fields; only the upper PC bits are needed to form the jump target.
module instr_field_decode
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:10] i_pc_hi,
  output decoded_instr_t     o_dec
);

  fmt_e w_fmt;

  assign w_fmt = fmt_e'(i_instr[FMT_HI:FMT_LO]);

  // Field extraction; every field not used by the format is forced to zero.
  always_comb begin
    o_dec = '0;
    case (w_fmt)
      FMT_R: begin
        o_dec.fmt    = FMT_R;
        o_dec.opcode = i_instr[OPC_HI:OPC_LO];
        o_dec.reg_d  = i_instr[RD_HI:RD_LO];
        o_dec.reg1   = i_instr[R1_HI:R1_LO];
        o_dec.reg2   = i_instr[R2_HI:R2_LO];
      end
      FMT_I: begin
        o_dec.fmt      = FMT_I;
        o_dec.opcode   = i_instr[OPC_HI:OPC_LO];
        o_dec.reg_d    = i_instr[RD_HI:RD_LO];
        o_dec.reg1     = i_instr[R1_HI:R1_LO];
        o_dec.imm      = i_instr[IMM_HI:IMM_LO];
        o_dec.imm_flag = 1'b1;
      end
      FMT_J: begin
        o_dec.fmt     = FMT_J;
        o_dec.opcode  = i_instr[OPC_HI:OPC_LO];
        o_dec.jmp_loc = {i_pc_hi, i_instr[JMP_HI:JMP_LO]};
      end
      FMT_RSV: begin
        // Reserved encodings leave the stage as a NOP tagged with format 11.
        o_dec.fmt = FMT_RSV;
      end
      default: begin
        o_dec = '0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// Instruction-fetch stage: PC, imem req/ack handshake and registered decode.
// Optional: FETCH_JMP_PREDECODE_EN follows format-10 jumps at fetch time.
module fetch_decode
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = PC_W,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_decode_if.master     imem,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               valid_o,
  output logic [1:0]         format_o,
  output logic [3:0]         opcode_o,
  output logic [2:0]         regD_o,
  output logic [2:0]         reg1_o,
  output logic [2:0]         reg2_o,
  output logic [2:0]         imm_o,
  output logic               immFlag_o,
  output logic [ADDR_W-1:0]  jmpLoc_o,
  output logic [ADDR_W-1:0]  pc_o
);

  localparam logic [1:0] S_BOOT  = BOOT;
  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_drain_addr;
  logic              r_valid;
  decoded_instr_t    r_dec;
  logic [ADDR_W-1:0] r_pc_out;

  logic              w_req;
  logic              w_ack;
  logic              w_accept;
  logic              w_consume;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;
  decoded_instr_t    w_dec;

  instr_field_decode #(
    .ADDR_W (ADDR_W)
  ) u_field_decode (
    .i_instr (imem.imem_data_i),
    .i_pc_hi (r_pc[ADDR_W-1:10]),
    .o_dec   (w_dec)
  );

  // Request is withheld only while a held instruction is stalled, so no
  // returned word can ever overwrite an unconsumed one.
  always_comb begin
    w_req = 1'b0;
    if (r_state == S_FETCH) begin
      w_req = !(r_valid && stall_i);
    end else if (r_state == S_DRAIN) begin
      w_req = 1'b1;
    end else begin
      w_req = 1'b0;
    end
  end

  assign w_ack     = w_req && imem.imem_ack_i;
  assign w_accept  = (r_state == S_FETCH) && w_ack && !redirect_i;
  assign w_consume = r_valid && !stall_i;
  assign w_pc_inc  = r_pc + ADDR_W'(1);

  // Next sequential PC, optionally following a jump seen at fetch time.
  always_comb begin
    w_pc_next = w_pc_inc;
`ifdef FETCH_JMP_PREDECODE_EN
    if (w_dec.fmt == FMT_J) begin
      w_pc_next = w_dec.jmp_loc;
    end else begin
      w_pc_next = w_pc_inc;
    end
`else
    w_pc_next = w_pc_inc;
`endif
  end

  assign imem.imem_req_o  = w_req;
  assign imem.imem_addr_o = (r_state == S_DRAIN) ? r_drain_addr : r_pc;

  // Fetch state machine; DRAIN keeps the abandoned request alive until acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_drain_addr <= {ADDR_W{1'b0}};
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (redirect_i && w_req && !imem.imem_ack_i) begin
            r_state      <= S_DRAIN;
            r_drain_addr <= r_pc;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem.imem_ack_i) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  // Program counter: redirect wins over a normal advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc <= redirect_pc_i;
    end else if (w_accept) begin
      r_pc <= w_pc_next;
    end else begin
      r_pc <= r_pc;
    end
  end

  // IF/ID output register with valid tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_dec    <= '0;
      r_pc_out <= {ADDR_W{1'b0}};
    end else if (redirect_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_dec    <= w_dec;
      r_pc_out <= r_pc;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign valid_o   = r_valid;
  assign format_o  = r_dec.fmt;
  assign opcode_o  = r_dec.opcode;
  assign regD_o    = r_dec.reg_d;
  assign reg1_o    = r_dec.reg1;
  assign reg2_o    = r_dec.reg2;
  assign imm_o     = r_dec.imm;
  assign immFlag_o = r_dec.imm_flag;
  assign jmpLoc_o  = r_dec.jmp_loc;
  assign pc_o      = r_pc_out;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: reset, streaming fetch, stall, drain on
// redirect, PC wrap, J/I/reserved decode and the FETCH_JMP_PREDECODE_EN path.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        ack_en;
  logic [15:0] mem_data;

  logic        valid_o;
  logic [1:0]  format_o;
  logic [3:0]  opcode_o;
  logic [2:0]  regD_o, reg1_o, reg2_o, imm_o;
  logic        immFlag_o;
  logic [15:0] jmpLoc_o, pc_o;

  logic        valid2;
  logic [1:0]  format2;
  logic [3:0]  opcode2;
  logic [2:0]  regD2, reg12, reg22, imm2;
  logic        immFlag2;
  logic [15:0] jmpLoc2, pc2;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_next;

  always #5 clk = ~clk;

  fetch_decode_if #(.ADDR_W(16)) imem_if ();
  fetch_decode_if #(.ADDR_W(16)) imem_if2 ();

  assign imem_if.imem_ack_i   = imem_if.imem_req_o & ack_en;
  assign imem_if.imem_data_i  = mem_data;
  assign imem_if2.imem_ack_i  = imem_if2.imem_req_o;
  assign imem_if2.imem_data_i = 16'h0A5A;

  fetch_decode #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk (clk), .rst_n (rst_n), .imem (imem_if),
    .stall_i (stall_i), .redirect_i (redirect_i), .redirect_pc_i (redirect_pc_i),
    .valid_o (valid_o), .format_o (format_o), .opcode_o (opcode_o),
    .regD_o (regD_o), .reg1_o (reg1_o), .reg2_o (reg2_o), .imm_o (imm_o),
    .immFlag_o (immFlag_o), .jmpLoc_o (jmpLoc_o), .pc_o (pc_o)
  );

  fetch_decode #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk (clk), .rst_n (rst_n), .imem (imem_if2),
    .stall_i (1'b0), .redirect_i (1'b0), .redirect_pc_i (16'h0000),
    .valid_o (valid2), .format_o (format2), .opcode_o (opcode2),
    .regD_o (regD2), .reg1_o (reg12), .reg2_o (reg22), .imm_o (imm2),
    .immFlag_o (immFlag2), .jmpLoc_o (jmpLoc2), .pc_o (pc2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 16'h0000;
    ack_en        = 1'b0;
    mem_data      = 16'h0A5A;
`ifdef FETCH_JMP_PREDECODE_EN
    exp_next = 16'h17FF;
`else
    exp_next = 16'h1401;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req", imem_if.imem_req_o, 16'd0);
    check("rst_valid", valid_o, 16'd0);
    check("rst_format", format_o, 16'd0);
    check("rst_regD", regD_o, 16'd0);
    check("rst_jmp", jmpLoc_o, 16'd0);
    check("rst_pc", pc_o, 16'd0);

    // Release; memory acks every cycle with 0A5A
    rst_n  = 1'b1;
    ack_en = 1'b1;
    #1;
    check("boot_req", imem_if.imem_req_o, 16'd0);
    @(negedge clk); #1;
    check("c2_req", imem_if.imem_req_o, 16'd1);
    check("c2_addr", imem_if.imem_addr_o, 16'h0000);
    check("c2_valid", valid_o, 16'd0);
    check("wrap_addr0", imem_if2.imem_addr_o, 16'hFFFF);
    @(negedge clk); #1;
    check("c3_valid", valid_o, 16'd1);
    check("c3_pc", pc_o, 16'h0000);
    check("c3_format", format_o, 16'd0);
    check("c3_opcode", opcode_o, 16'd2);
    check("c3_regD", regD_o, 16'd4);
    check("c3_reg1", reg1_o, 16'd5);
    check("c3_reg2", reg2_o, 16'd5);
    check("c3_immFlag", immFlag_o, 16'd0);
    check("c3_addr", imem_if.imem_addr_o, 16'h0001);
    check("wrap_pc0", pc2, 16'hFFFF);
    check("wrap_addr1", imem_if2.imem_addr_o, 16'h0000);
    @(negedge clk); #1;
    check("c4_pc", pc_o, 16'h0001);
    check("wrap_pc1", pc2, 16'h0000);

    // Stall for three cycles while valid
    stall_i = 1'b1;
    #1;
    check("st0_req", imem_if.imem_req_o, 16'd0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk); #1;
      check("st_req", imem_if.imem_req_o, 16'd0);
      check("st_valid", valid_o, 16'd1);
      check("st_pc", pc_o, 16'h0001);
      check("st_regD", regD_o, 16'd4);
    end
    @(negedge clk);
    stall_i = 1'b0;
    #1;
    check("unst_req", imem_if.imem_req_o, 16'd1);
    check("unst_addr", imem_if.imem_addr_o, 16'h0002);
    @(negedge clk); #1;
    check("unst_pc", pc_o, 16'h0002);
    check("unst_valid", valid_o, 16'd1);

    // Ack withheld, then redirect before the late ack -> DRAIN
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("wait_valid", valid_o, 16'd0);
      check("wait_addr", imem_if.imem_addr_o, 16'h0003);
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 16'h0100;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    check("drain_req", imem_if.imem_req_o, 16'd1);
    check("drain_addr", imem_if.imem_addr_o, 16'h0003);
    check("drain_valid", valid_o, 16'd0);
    mem_data = 16'hFFFF;
    ack_en   = 1'b1;
    @(negedge clk); #1;
    check("drop_valid", valid_o, 16'd0);
    check("drop_addr", imem_if.imem_addr_o, 16'h0100);
    check("drop_req", imem_if.imem_req_o, 16'd1);
    mem_data = 16'h4BB6;
    @(negedge clk); #1;
    check("i_valid", valid_o, 16'd1);
    check("i_pc", pc_o, 16'h0100);
    check("i_format", format_o, 16'd1);
    check("i_regD", regD_o, 16'd7);
    check("i_reg1", reg1_o, 16'd3);
    check("i_imm", imm_o, 16'd3);
    check("i_reg2", reg2_o, 16'd0);
    check("i_immFlag", immFlag_o, 16'd1);

    // Redirect with simultaneous ack: word dropped, no DRAIN
    redirect_i    = 1'b1;
    redirect_pc_i = 16'h1400;
    mem_data      = 16'hC123;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    check("rdack_valid", valid_o, 16'd0);
    check("rdack_addr", imem_if.imem_addr_o, 16'h1400);
    mem_data = 16'h83FF;
    @(negedge clk); #1;
    check("j_valid", valid_o, 16'd1);
    check("j_format", format_o, 16'd2);
    check("j_jmpLoc", jmpLoc_o, 16'h17FF);
    check("j_pc", pc_o, 16'h1400);
    check("j_regD", regD_o, 16'd0);
    check("j_immFlag", immFlag_o, 16'd0);
    check("j_next_addr", imem_if.imem_addr_o, exp_next);

    // Reserved format emitted as NOP
    mem_data = 16'hC123;
    @(negedge clk); #1;
    check("nop_valid", valid_o, 16'd1);
    check("nop_format", format_o, 16'd3);
    check("nop_opcode", opcode_o, 16'd0);
    check("nop_regD", regD_o, 16'd0);
    check("nop_reg1", reg1_o, 16'd0);
    check("nop_reg2", reg2_o, 16'd0);
    check("nop_imm", imm_o, 16'd0);
    check("nop_immFlag", immFlag_o, 16'd0);
    check("nop_jmp", jmpLoc_o, 16'd0);
    check("nop_pc", pc_o, exp_next);

    ack_en = 1'b0;
    @(negedge clk); #1;
    check("consumed_valid", valid_o, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
